// File: rtl/rf_arb_pkg.sv
// Shared types and helpers for the register-file write-port arbiter.
package rf_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } rf_arb_state_t;

  // All-ones register index, which addresses the PC in the register file.
  function automatic int unsigned pc_index(input int unsigned sel_width);
    return (32'd1 << sel_width) - 32'd1;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_chk.sv
// Protocol assertions for the write arbiter; no functional logic.
module rf_write_arbiter_chk #(
  parameter int NUM_REQ = 3
) (
  input logic               clk,
  input logic               reset,
  input logic [NUM_REQ-1:0] req_valid,
  input logic [NUM_REQ-1:0] req_ready,
  input logic               rf_sel_en,
  input logic               pc_write,
  input logic               locked,
  input logic               lock_abort
);

  a_ready_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
  a_ready_needs_valid: assert property (@(posedge clk) disable iff (reset)
    (req_ready & ~req_valid) == {NUM_REQ{1'b0}});
  a_ready_off_in_reset: assert property (@(posedge clk) reset |-> (req_ready == {NUM_REQ{1'b0}}));
  a_pc_implies_en: assert property (@(posedge clk) disable iff (reset) pc_write |-> rf_sel_en);
  a_abort_when_locked: assert property (@(posedge clk) disable iff (reset) lock_abort |-> locked);

endmodule

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Combinational rotate-priority picker: first requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW:0] sum_s;
  logic [IW:0] idx_s;
  logic        hit_s;

  // Scan N slots starting at ptr; the first pending slot wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    sum_s   = '0;
    idx_s   = '0;
    hit_s   = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum_s   = {1'b0, ptr} + (IW+1)'(k);
      idx_s   = (sum_s >= (IW+1)'(N)) ? (sum_s - (IW+1)'(N)) : sum_s;
      hit_s   = req[idx_s] & ~any;
      gnt_idx = hit_s ? idx_s[IW-1:0] : gnt_idx;
      any     = any | hit_s;
    end
    gnt[gnt_idx] = any;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port, with grant lock and watchdog.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int bit_width    = 32,
  parameter int sel_width    = 5,
  parameter int NUM_REQ      = 3,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_lock,
  input  logic [NUM_REQ*sel_width-1:0]   req_sel,
  input  logic [NUM_REQ*bit_width-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           rf_sel_en,
  output logic [sel_width-1:0]           rf_sel_c,
  output logic [bit_width-1:0]           rf_data_in,
  output logic                           pc_write,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           locked,
  output logic                           lock_abort
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0]        CNT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [sel_width-1:0] PC_IDX   = sel_width'(pc_index(sel_width));

  rf_arb_state_t          state_r;
  logic [IW-1:0]          ptr_r;
  logic [IW-1:0]          owner_r;
  logic [CW-1:0]          cnt_r;
  logic                   rf_sel_en_r;
  logic [sel_width-1:0]   rf_sel_c_r;
  logic [bit_width-1:0]   rf_data_r;
  logic                   pc_write_r;
  logic [IW-1:0]          grant_id_r;

  logic [NUM_REQ-1:0]     arb_gnt_s;
  logic [IW-1:0]          arb_idx_s;
  logic                   arb_any_s;
  logic [NUM_REQ-1:0]     req_ready_s;
  logic                   hs_s;
  logic [IW-1:0]          hs_idx_s;
  logic                   abort_s;
  logic [sel_width-1:0]   sel_mux_s;
  logic [bit_width-1:0]   data_mux_s;
  logic                   lock_mux_s;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(NUM_REQ - 1)) ? '0 : (i + IW'(1));
  endfunction

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req     (req_valid),
    .ptr     (ptr_r),
    .gnt     (arb_gnt_s),
    .gnt_idx (arb_idx_s),
    .any     (arb_any_s)
  );

  // Ready/handshake decode; ready depends only on valid, state and pointer.
  always_comb begin
    req_ready_s = '0;
    hs_s        = 1'b0;
    hs_idx_s    = '0;
    abort_s     = 1'b0;
    if (reset) begin
      req_ready_s = '0;
    end else begin
      case (state_r)
        ARB: begin
          req_ready_s = arb_gnt_s;
          hs_s        = arb_any_s;
          hs_idx_s    = arb_idx_s;
        end
        LOCKED: begin
          req_ready_s[owner_r] = req_valid[owner_r];
          hs_s                 = req_valid[owner_r];
          hs_idx_s             = owner_r;
          abort_s              = ~req_valid[owner_r] & (cnt_r == CNT_LAST);
        end
        default: begin
          req_ready_s = '0;
        end
      endcase
    end
  end

  // Select the handshaking requester's payload (AND-OR mux, one-hot by index).
  always_comb begin
    sel_mux_s  = '0;
    data_mux_s = '0;
    lock_mux_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_mux_s  = sel_mux_s  | (req_sel[i*sel_width +: sel_width] & {sel_width{hs_idx_s == IW'(i)}});
      data_mux_s = data_mux_s | (req_data[i*bit_width +: bit_width] & {bit_width{hs_idx_s == IW'(i)}});
      lock_mux_s = lock_mux_s | (req_lock[i] & (hs_idx_s == IW'(i)));
    end
  end

  // FSM, pointer, watchdog and registered write-port stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ARB;
      ptr_r       <= '0;
      owner_r     <= '0;
      cnt_r       <= '0;
      rf_sel_en_r <= 1'b0;
      rf_sel_c_r  <= '0;
      rf_data_r   <= '0;
      pc_write_r  <= 1'b0;
      grant_id_r  <= '0;
    end else begin
      rf_sel_en_r <= hs_s;
      if (hs_s) begin
        rf_sel_c_r <= sel_mux_s;
        rf_data_r  <= data_mux_s;
        grant_id_r <= hs_idx_s;
        pc_write_r <= (sel_mux_s == PC_IDX);
      end else begin
        pc_write_r <= 1'b0;
      end

      case (state_r)
        ARB: begin
          if (hs_s) begin
            ptr_r <= next_idx(hs_idx_s);
            if (lock_mux_s) begin
              state_r <= LOCKED;
              owner_r <= hs_idx_s;
              cnt_r   <= '0;
            end
          end
        end
        LOCKED: begin
          if (hs_s) begin
            if (lock_mux_s) begin
              cnt_r <= '0;
            end else begin
              state_r <= ARB;
              ptr_r   <= next_idx(owner_r);
            end
          end else if (abort_s) begin
            state_r <= ARB;
            ptr_r   <= next_idx(owner_r);
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= ARB;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_s;
  assign rf_sel_en  = rf_sel_en_r;
  assign rf_sel_c   = rf_sel_c_r;
  assign rf_data_in = rf_data_r;
  assign pc_write   = pc_write_r;
  assign grant_id   = grant_id_r;
  assign locked     = (state_r == LOCKED);
  // Abort is flagged in the cycle the watchdog fires, while no grant can be issued.
  assign lock_abort = abort_s;

  rf_write_arbiter_chk #(.NUM_REQ(NUM_REQ)) u_chk (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready_s),
    .rf_sel_en  (rf_sel_en_r),
    .pc_write   (pc_write_r),
    .locked     (state_r == LOCKED),
    .lock_abort (abort_s)
  );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (3 requesters, LOCK_TIMEOUT=4).
module tb_rf_write_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_lock;
  logic [4:0]  sel_a [3];
  logic [31:0] data_a [3];
  logic [14:0] req_sel;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        rf_sel_en;
  logic [4:0]  rf_sel_c;
  logic [31:0] rf_data_in;
  logic        pc_write;
  logic [1:0]  grant_id;
  logic        locked;
  logic        lock_abort;

  int checks = 0;
  int errors = 0;

  assign req_sel  = {sel_a[2], sel_a[1], sel_a[0]};
  assign req_data = {data_a[2], data_a[1], data_a[0]};

  rf_write_arbiter #(
    .bit_width(32), .sel_width(5), .NUM_REQ(3), .LOCK_TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_lock(req_lock),
    .req_sel(req_sel), .req_data(req_data), .req_ready(req_ready),
    .rf_sel_en(rf_sel_en), .rf_sel_c(rf_sel_c), .rf_data_in(rf_data_in),
    .pc_write(pc_write), .grant_id(grant_id), .locked(locked), .lock_abort(lock_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic clear_reqs();
    req_valid = 3'b000;
    req_lock  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      sel_a[i]  = 5'd0;
      data_a[i] = 32'd0;
    end
  endtask

  task automatic apply_reset();
    clear_reqs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 3'b111;
    sel_a[0] = 5'd1; sel_a[1] = 5'd2; sel_a[2] = 5'd3;
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 3'b000) begin
        errors++; $display("FAIL reset_ready: got %b expected 000", req_ready);
      end
      checks++;
      if ({rf_sel_en, pc_write, locked, lock_abort, grant_id, rf_sel_c, rf_data_in} !== 43'd0) begin
        errors++;
        $display("FAIL reset_outputs: got en=%b pc=%b lk=%b ab=%b gid=%0d sel=%0h data=%0h expected all 0",
                 rf_sel_en, pc_write, locked, lock_abort, grant_id, rf_sel_c, rf_data_in);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++; $display("FAIL reset_first_ready: got %b expected 001", req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({rf_sel_en, grant_id, rf_sel_c} !== {1'b1, 2'd0, 5'd1}) begin
      errors++; $display("FAIL reset_first_grant: got en=%b gid=%0d sel=%0d expected en=1 gid=0 sel=1",
                         rf_sel_en, grant_id, rf_sel_c);
    end
    clear_reqs();
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g [4];
    logic [4:0]  exp_s [4];
    logic [31:0] exp_d [4];
    exp_g = '{2'd0, 2'd1, 2'd2, 2'd0};
    exp_s = '{5'd1, 5'd2, 5'd3, 5'd1};
    exp_d = '{32'hA0, 32'hB0, 32'hC0, 32'hA0};
    apply_reset();
    req_valid = 3'b111;
    sel_a[0] = 5'd1;  sel_a[1] = 5'd2;  sel_a[2] = 5'd3;
    data_a[0] = 32'hA0; data_a[1] = 32'hB0; data_a[2] = 32'hC0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (req_ready !== (3'b001 << exp_g[k])) begin
        errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, 3'b001 << exp_g[k]);
      end
      @(posedge clk); #1;
      checks++;
      if ({rf_sel_en, grant_id, rf_sel_c, rf_data_in} !== {1'b1, exp_g[k], exp_s[k], exp_d[k]}) begin
        errors++; $display("FAIL rr_write[%0d]: got en=%b gid=%0d sel=%0d data=%0h expected en=1 gid=%0d sel=%0d data=%0h",
                           k, rf_sel_en, grant_id, rf_sel_c, rf_data_in, exp_g[k], exp_s[k], exp_d[k]);
      end
    end
    clear_reqs();
  endtask

  task automatic test_lock();
    logic [4:0] exp_s [3];
    exp_s = '{5'd4, 5'd5, 5'd6};
    apply_reset();
    req_valid = 3'b010; req_lock = 3'b010;
    sel_a[1] = 5'd4; data_a[1] = 32'h44;
    sel_a[0] = 5'd7; sel_a[2] = 5'd8;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (req_ready !== 3'b010) begin
        errors++; $display("FAIL lock_ready[%0d]: got %b expected 010", k, req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if ({rf_sel_en, grant_id, rf_sel_c} !== {1'b1, 2'd1, exp_s[k]}) begin
        errors++; $display("FAIL lock_write[%0d]: got en=%b gid=%0d sel=%0d expected en=1 gid=1 sel=%0d",
                           k, rf_sel_en, grant_id, rf_sel_c, exp_s[k]);
      end
      checks++;
      if (locked !== (k < 2)) begin
        errors++; $display("FAIL lock_state[%0d]: got %b expected %b", k, locked, (k < 2));
      end
      req_valid = (k < 2) ? 3'b111 : 3'b101;
      req_lock  = (k == 0) ? 3'b010 : 3'b000;
      sel_a[1]  = exp_s[(k < 2) ? k + 1 : 2];
    end
    #1;
    checks++;
    if (req_ready !== 3'b100) begin
      errors++; $display("FAIL lock_next_ready: got %b expected 100", req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({rf_sel_en, grant_id, rf_sel_c} !== {1'b1, 2'd2, 5'd8}) begin
      errors++; $display("FAIL lock_next_grant: got en=%b gid=%0d sel=%0d expected en=1 gid=2 sel=8",
                         rf_sel_en, grant_id, rf_sel_c);
    end
    clear_reqs();
  endtask

  task automatic test_watchdog();
    int pulses;
    pulses = 0;
    apply_reset();
    req_valid = 3'b001; req_lock = 3'b001; sel_a[0] = 5'd9;
    @(posedge clk); #1;
    checks++;
    if ({locked, rf_sel_en, rf_sel_c} !== {1'b1, 1'b1, 5'd9}) begin
      errors++; $display("FAIL wd_lock: got lk=%b en=%b sel=%0d expected lk=1 en=1 sel=9", locked, rf_sel_en, rf_sel_c);
    end
    req_valid = 3'b010; req_lock = 3'b000; sel_a[1] = 5'd10;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (lock_abort === 1'b1) pulses++;
      checks++;
      if ({lock_abort, req_ready} !== {(k == 3), 3'b000}) begin
        errors++; $display("FAIL wd_cycle[%0d]: got abort=%b ready=%b expected abort=%b ready=000",
                           k, lock_abort, req_ready, (k == 3));
      end
      @(posedge clk); #1;
    end
    #1;
    checks++;
    if ({lock_abort, locked, req_ready} !== {1'b0, 1'b0, 3'b010}) begin
      errors++; $display("FAIL wd_release: got abort=%b lk=%b ready=%b expected abort=0 lk=0 ready=010",
                         lock_abort, locked, req_ready);
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL wd_pulse_count: got %0d expected 1", pulses);
    end
    @(posedge clk); #1;
    checks++;
    if ({rf_sel_en, grant_id, rf_sel_c} !== {1'b1, 2'd1, 5'd10}) begin
      errors++; $display("FAIL wd_next_grant: got en=%b gid=%0d sel=%0d expected en=1 gid=1 sel=10",
                         rf_sel_en, grant_id, rf_sel_c);
    end
    clear_reqs();
  endtask

  task automatic test_pc_write();
    apply_reset();
    req_valid = 3'b100; sel_a[2] = 5'h1F; data_a[2] = 32'h100;
    @(posedge clk); #1;
    checks++;
    if ({rf_sel_en, rf_sel_c, pc_write, grant_id, rf_data_in} !== {1'b1, 5'h1F, 1'b1, 2'd2, 32'h100}) begin
      errors++; $display("FAIL pc_write: got en=%b sel=%0h pc=%b gid=%0d data=%0h expected en=1 sel=1f pc=1 gid=2 data=100",
                         rf_sel_en, rf_sel_c, pc_write, grant_id, rf_data_in);
    end
    clear_reqs();
    @(posedge clk); #1;
    checks++;
    if ({rf_sel_en, pc_write, rf_sel_c} !== {1'b0, 1'b0, 5'h1F}) begin
      errors++; $display("FAIL pc_idle: got en=%b pc=%b sel=%0h expected en=0 pc=0 sel=1f", rf_sel_en, pc_write, rf_sel_c);
    end
  endtask

  task automatic test_reset_mid_lock();
    apply_reset();
    req_valid = 3'b010; req_lock = 3'b010; sel_a[1] = 5'd3;
    @(posedge clk); #1;
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL rml_locked: got %b expected 1", locked);
    end
    sel_a[1] = 5'd4;
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 3'b000) begin
      errors++; $display("FAIL rml_ready: got %b expected 000", req_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({rf_sel_en, locked, lock_abort} !== 3'b000) begin
      errors++; $display("FAIL rml_outputs: got en=%b lk=%b ab=%b expected 0 0 0", rf_sel_en, locked, lock_abort);
    end
    req_valid = 3'b111; req_lock = 3'b000; sel_a[0] = 5'd11;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++; $display("FAIL rml_pointer: got %b expected 001", req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({rf_sel_en, grant_id, rf_sel_c} !== {1'b1, 2'd0, 5'd11}) begin
      errors++; $display("FAIL rml_grant: got en=%b gid=%0d sel=%0d expected en=1 gid=0 sel=11",
                         rf_sel_en, grant_id, rf_sel_c);
    end
    clear_reqs();
  endtask

  initial begin
    reset = 1'b1;
    clear_reqs();
    test_reset();
    test_round_robin();
    test_lock();
    test_watchdog();
    test_pc_write();
    test_reset_mid_lock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
